// File: rtl/circle_point_sequencer_pkg.sv
// rtl/circle_point_sequencer_pkg.sv - shared states and screen constants for the point sequencer
package circle_point_sequencer_pkg;

  localparam int DEFAULT_H_RES = 640;
  localparam int DEFAULT_V_RES = 480;
  localparam int COORD_W       = 10;
  localparam int COLOR_W       = 12;
  localparam int NUM_PTS       = 8;
  localparam int IDX_W         = 3;

  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_SCAN = 2'd1,
    CS_EMIT = 2'd2
  } cs_state_t;

endpackage

// File: rtl/circle_point_sequencer_point_filter.sv
// rtl/circle_point_sequencer_point_filter.sv - clip and earlier-duplicate filter for one point of a group
module point_filter
  import circle_point_sequencer_pkg::*;
#(
  parameter int H_RES = DEFAULT_H_RES,
  parameter int V_RES = DEFAULT_V_RES
) (
  input  logic [NUM_PTS*COORD_W-1:0] i_pts_x,
  input  logic [NUM_PTS*COORD_W-1:0] i_pts_y,
  input  logic [IDX_W-1:0]           i_idx,
  output logic                       o_keep
);

  // One extra bit so a resolution of 1024 still compares correctly.
  localparam logic [COORD_W:0] LP_H_LIM = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] LP_V_LIM = (COORD_W+1)'(V_RES);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_dup;

  // Select the point under test, then look for a raw-coordinate match among earlier points.
  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_dup = 1'b0;
    for (int i = 0; i < NUM_PTS; i++) begin
      if (i_idx == IDX_W'(i)) begin
        w_x = i_pts_x[i*COORD_W +: COORD_W];
        w_y = i_pts_y[i*COORD_W +: COORD_W];
      end
    end
    for (int j = 0; j < NUM_PTS - 1; j++) begin
      if ((IDX_W'(j) < i_idx) &&
          (i_pts_x[j*COORD_W +: COORD_W] == w_x) &&
          (i_pts_y[j*COORD_W +: COORD_W] == w_y)) begin
        w_dup = 1'b1;
      end
    end
    o_keep = ({1'b0, w_x} < LP_H_LIM) && ({1'b0, w_y} < LP_V_LIM) && !w_dup;
  end

endmodule

// File: rtl/circle_point_sequencer.sv
// rtl/circle_point_sequencer.sv - serialises an eight-point octant group into single visible pixels
module circle_point_sequencer
  import circle_point_sequencer_pkg::*;
#(
  parameter int H_RES = DEFAULT_H_RES,
  parameter int V_RES = DEFAULT_V_RES
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        in_rts,
  output logic        in_rtr,
  input  logic [9:0]  pt_x_0,
  input  logic [9:0]  pt_x_1,
  input  logic [9:0]  pt_x_2,
  input  logic [9:0]  pt_x_3,
  input  logic [9:0]  pt_x_4,
  input  logic [9:0]  pt_x_5,
  input  logic [9:0]  pt_x_6,
  input  logic [9:0]  pt_x_7,
  input  logic [9:0]  pt_y_0,
  input  logic [9:0]  pt_y_1,
  input  logic [9:0]  pt_y_2,
  input  logic [9:0]  pt_y_3,
  input  logic [9:0]  pt_y_4,
  input  logic [9:0]  pt_y_5,
  input  logic [9:0]  pt_y_6,
  input  logic [9:0]  pt_y_7,
  input  logic [11:0] color,
  output logic        out_rts,
  input  logic        out_rtr,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_color,
  output logic        busy
);

  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_PTS - 1);

  cs_state_t                  r_state;
  cs_state_t                  w_next_state;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           w_next_idx;
  logic                       w_load_grp;
  logic                       w_load_pix;
  logic                       w_keep;
  logic [NUM_PTS*COORD_W-1:0] r_pts_x;
  logic [NUM_PTS*COORD_W-1:0] r_pts_y;
  logic [COLOR_W-1:0]         r_color;
  logic [COORD_W-1:0]         r_pix_x;
  logic [COORD_W-1:0]         r_pix_y;
  logic [COLOR_W-1:0]         r_pix_color;
  logic [COORD_W-1:0]         w_sel_x;
  logic [COORD_W-1:0]         w_sel_y;

  point_filter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_point_filter (
    .i_pts_x (r_pts_x),
    .i_pts_y (r_pts_y),
    .i_idx   (r_idx),
    .o_keep  (w_keep)
  );

  assign in_rtr    = (r_state == CS_IDLE);
  assign out_rts   = (r_state == CS_EMIT);
  assign busy      = (r_state != CS_IDLE);
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_color = r_pix_color;

  // Point currently addressed by idx, loaded into the pixel registers when kept.
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NUM_PTS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_x = r_pts_x[i*COORD_W +: COORD_W];
        w_sel_y = r_pts_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Next-state logic: accept a group, scan points one per cycle, hold each kept pixel until taken.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_load_grp   = 1'b0;
    w_load_pix   = 1'b0;
    case (r_state)
      CS_IDLE: begin
        if (in_rts) begin
          w_load_grp   = 1'b1;
          w_next_idx   = '0;
          w_next_state = CS_SCAN;
        end
      end
      CS_SCAN: begin
        if (w_keep) begin
          w_load_pix   = 1'b1;
          w_next_state = CS_EMIT;
        end else if (r_idx == LP_LAST_IDX) begin
          w_next_state = CS_IDLE;
        end else begin
          w_next_idx = r_idx + 1'b1;
        end
      end
      CS_EMIT: begin
        if (out_rtr) begin
          if (r_idx == LP_LAST_IDX) begin
            w_next_state = CS_IDLE;
          end else begin
            w_next_idx   = r_idx + 1'b1;
            w_next_state = CS_SCAN;
          end
        end
      end
      default: w_next_state = CS_IDLE;
    endcase
  end

  // State and index register; reset abandons any group in flight.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state <= CS_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  // Group latch and registered pixel outputs, which only change on a load so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_pts_x     <= '0;
      r_pts_y     <= '0;
      r_color     <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
    end else begin
      if (w_load_grp) begin
        r_pts_x <= {pt_x_7, pt_x_6, pt_x_5, pt_x_4, pt_x_3, pt_x_2, pt_x_1, pt_x_0};
        r_pts_y <= {pt_y_7, pt_y_6, pt_y_5, pt_y_4, pt_y_3, pt_y_2, pt_y_1, pt_y_0};
        r_color <= color;
      end
      if (w_load_pix) begin
        r_pix_x     <= w_sel_x;
        r_pix_y     <= w_sel_y;
        r_pix_color <= r_color;
      end
    end
  end

endmodule

// File: tb/tb_circle_point_sequencer.sv
// tb/tb_circle_point_sequencer.sv - randomized self-checking bench for circle_point_sequencer
module tb_circle_point_sequencer;

  logic        clk = 1'b0;
  logic        rst_;
  logic        in_rts;
  logic        in_rtr;
  logic [9:0]  pt_x [8];
  logic [9:0]  pt_y [8];
  logic [11:0] color;
  logic        out_rts;
  logic        out_rtr;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_color;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] g_x [8];
  logic [9:0] g_y [8];

  always #5 clk = ~clk;

  circle_point_sequencer dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_rts    (in_rts),
    .in_rtr    (in_rtr),
    .pt_x_0    (pt_x[0]), .pt_x_1 (pt_x[1]), .pt_x_2 (pt_x[2]), .pt_x_3 (pt_x[3]),
    .pt_x_4    (pt_x[4]), .pt_x_5 (pt_x[5]), .pt_x_6 (pt_x[6]), .pt_x_7 (pt_x[7]),
    .pt_y_0    (pt_y[0]), .pt_y_1 (pt_y[1]), .pt_y_2 (pt_y[2]), .pt_y_3 (pt_y[3]),
    .pt_y_4    (pt_y[4]), .pt_y_5 (pt_y[5]), .pt_y_6 (pt_y[6]), .pt_y_7 (pt_y[7]),
    .color     (color),
    .out_rts   (out_rts),
    .out_rtr   (out_rtr),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present g_x/g_y with the given color for one handshake (DUT is idle on entry).
  task automatic offer_group(input logic [11:0] col);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pt_x[i] = g_x[i];
      pt_y[i] = g_y[i];
    end
    color  = col;
    in_rts = 1'b1;
    check_val("in_rtr_before_group", {31'd0, in_rtr}, 32'd1);
    @(posedge clk);
    #1 in_rts = 1'b0;
  endtask

  // Run one group through the DUT and compare against a list built from the visibility/duplicate rules.
  task automatic run_group(input logic [11:0] col, input bit rand_rtr, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int first_kept = -1;
    int first_k = 0;
    int idle_k = 0;
    bit pend = 1'b0;
    logic [31:0] pend_pix = '0;
    for (int i = 0; i < 8; i++) begin
      bit keep = (g_x[i] < 10'd640) && (g_y[i] < 10'd480);
      for (int j = 0; j < i; j++)
        if (g_x[j] == g_x[i] && g_y[j] == g_y[i]) keep = 1'b0;
      if (keep) begin
        exp_q.push_back({g_x[i], g_y[i], col});
        if (first_kept < 0) first_kept = i;
      end
    end
    offer_group(col);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      out_rtr = rand_rtr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend) check_val({tag, "_hold"}, {out_rts, pix_x, pix_y, pix_color[10:0]}, {1'b1, pend_pix[31:12], pend_pix[10:0]});
      if (out_rts && first_k == 0) first_k = k;
      pend = out_rts && !out_rtr;
      pend_pix = {pix_x, pix_y, pix_color};
      if (out_rts && out_rtr) got_q.push_back({pix_x, pix_y, pix_color});
      if (!busy) begin
        idle_k = k;
        break;
      end
    end
    check_val({tag, "_done"}, {31'd0, idle_k != 0}, 32'd1);
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val({tag, "_pix"}, got_q[i], exp_q[i]);
    if (!rand_rtr) begin
      check_val({tag, "_first_rts"}, first_k, (first_kept < 0) ? 0 : first_kept + 2);
      check_val({tag, "_idle_at"}, idle_k, 9 + exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_    = 1'b1;
    in_rts  = 1'b0;
    out_rtr = 1'b0;
    color   = '0;
    for (int i = 0; i < 8; i++) begin
      pt_x[i] = '0;
      pt_y[i] = '0;
    end

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_rts", {31'd0, out_rts}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_pix", {pix_x, pix_y, pix_color}, 32'd0);
    rst_ = 1'b0;
    @(negedge clk);
    check_val("rst_in_rtr", {31'd0, in_rtr}, 32'd1);

    // Eight distinct in-range points.
    for (int i = 0; i < 8; i++) begin
      g_x[i] = 10'(10 + i);
      g_y[i] = 10'(20 + i);
    end
    run_group(12'hF00, 1'b0, "distinct");

    // Zero radius: eight copies of the center.
    for (int i = 0; i < 8; i++) begin
      g_x[i] = 10'd100;
      g_y[i] = 10'd100;
    end
    run_group(12'h0A5, 1'b0, "r0");

    // Clip and duplicate mix around (5,5).
    g_x[0] = 10'd15;   g_y[0] = 10'd5;
    g_x[1] = 10'd5;    g_y[1] = 10'd15;
    g_x[2] = 10'd5;    g_y[2] = 10'd15;
    g_x[3] = 10'd1019; g_y[3] = 10'd5;
    g_x[4] = 10'd1019; g_y[4] = 10'd5;
    g_x[5] = 10'd5;    g_y[5] = 10'd1019;
    g_x[6] = 10'd5;    g_y[6] = 10'd1019;
    g_x[7] = 10'd15;   g_y[7] = 10'd5;
    run_group(12'h123, 1'b0, "clipdup");

    // Everything off screen horizontally.
    for (int i = 0; i < 8; i++) begin
      g_x[i] = 10'd700;
      g_y[i] = 10'(50 + i);
    end
    run_group(12'hFFF, 1'b0, "alloff");

    // Edge of screen: 639/479 visible, 640/480 clipped, last point alone visible.
    g_x[0] = 10'd640; g_y[0] = 10'd0;
    g_x[1] = 10'd0;   g_y[1] = 10'd480;
    g_x[2] = 10'd640; g_y[2] = 10'd480;
    g_x[3] = 10'd640; g_y[3] = 10'd0;
    g_x[4] = 10'd700; g_y[4] = 10'd1;
    g_x[5] = 10'd2;   g_y[5] = 10'd500;
    g_x[6] = 10'd1023; g_y[6] = 10'd1023;
    g_x[7] = 10'd639; g_y[7] = 10'd479;
    run_group(12'h777, 1'b0, "edge");

    // Backpressure on the first pixel, then reset during the second pixel.
    for (int i = 0; i < 8; i++) begin
      g_x[i] = 10'(30 + 2 * i);
      g_y[i] = 10'(40 + 3 * i);
    end
    out_rtr = 1'b0;
    offer_group(12'h5A5);
    for (int k = 0; k < 10 && !out_rts; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_val("bp_rts", {31'd0, out_rts}, 32'd1);
      check_val("bp_pix", {pix_x, pix_y, pix_color}, {10'd30, 10'd40, 12'h5A5});
      @(negedge clk);
    end
    out_rtr = 1'b1;
    @(negedge clk);
    check_val("bp_taken", {31'd0, out_rts}, 32'd0);
    out_rtr = 1'b0;
    for (int k = 0; k < 10 && !out_rts; k++) @(negedge clk);
    check_val("bp_second", {out_rts, pix_x, pix_y, pix_color[10:0]}, {1'b1, 10'd32, 10'd43, 11'h5A5});
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    out_rtr = 1'b1;
    check_val("midrst_rts", {31'd0, out_rts}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_in_rtr", {31'd0, in_rtr}, 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_rts || busy) seen++;
      end
      check_val("midrst_quiet", seen, 0);
    end

    // Random groups drawn from a small pool so duplicates and clipped points are common.
    for (int g = 0; g < 30; g++) begin
      logic [9:0] px [4];
      logic [9:0] py [4];
      px[0] = 10'($urandom_range(0, 639));
      px[1] = 10'($urandom_range(0, 639));
      px[2] = 10'($urandom_range(640, 1023));
      px[3] = px[0];
      py[0] = 10'($urandom_range(0, 479));
      py[1] = 10'($urandom_range(0, 479));
      py[2] = 10'($urandom_range(480, 1023));
      py[3] = py[1];
      for (int i = 0; i < 8; i++) begin
        g_x[i] = px[$urandom_range(0, 3)];
        g_y[i] = py[$urandom_range(0, 3)];
      end
      run_group(12'($urandom), (g % 2) == 1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
